dt1_muldiv_seq: RTL and testbench
=================================

Name: dt1_muldiv_seq

Overview:
Parametrised iterative multiply/divide execution unit implementing the full RV32M op set (selected by funct3), extending the single-cycle ALU path with multi-cycle operations. Sits beside the ALU in the execute stage, behind the ALU decoder, and is issued only for R-type ops with funct7 = 0000001. Uses a radix-2 shift-add multiplier and a restoring divider, one bit per cycle, with valid/ready handshakes on both input and output.

Parameters:
XLEN, 32, operand/result width; must be ≥ 4. Internal counter width is $clog2(XLEN+1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
kill  in  1  synchronous abort (pipeline flush)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  result value
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, result=0, busy=0, counter=0. Datapath registers clear.
- in_ready=(state==IDLE). A request is accepted on the edge where in_valid & in_ready are both high. On that edge, funct3, a and b are captured.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE → CALC on a normal accept. IDLE → DONE on a special-case accept.
- CALC → FIX after exactly XLEN cycles in CALC.
- FIX → DONE after one cycle.
- DONE → IDLE on out_valid & out_ready.
- kill=1 forces state to IDLE on the next edge from any state. It discards the op, clears out_valid, and takes priority over accept and over the completion handshake.
- Latency (the cycle after the accept edge counts as 1):
  - Normal ops: out_valid first high in cycle XLEN+2 (34 at XLEN=32).
  - Special cases: out_valid high in cycle 1.
- out_valid=(state==DONE). result is held stable while out_valid=1 and out_ready=0; out_valid stays asserted indefinitely under backpressure.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Signed operands are converted to magnitudes at accept; the sign is applied in FIX.
- Multiply: 2*XLEN-bit accumulator. Each CALC cycle, if the multiplier LSB is 1, add the multiplicand into the upper half, then shift right by 1.
  - FIX negates the 2*XLEN product if the operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring. Each CALC cycle, shift {rem, quot} left by 1, trial-subtract the divisor, and keep the subtraction if it is non-negative (setting quot LSB=1).
  - FIX: quotient is negated if the signs of a and b differ. Remainder takes the sign of a (the dividend).
- Special cases, resolved at accept with no CALC cycles:
  - b==0: DIV and DIVU return all-ones; REM and REMU return a.
  - Signed overflow (DIV or REM with a=2^(XLEN-1), b=all-ones): DIV returns a, REM returns 0.
  - Multiply by zero is not special-cased and takes full latency.
- Any in_valid asserted while in_ready=0 is ignored. The source must hold the request until it is accepted.

Test Plan:
- Reset with out_ready=1; MUL a=7, b=0xFFFFFFFD (-3) → out_valid in cycle 34, result=0xFFFFFFEB, busy high cycles 1–33. Then MULH a=b=0x80000000 → 0x40000000; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each completes in 34 cycles.
- DIVU a=0x1234, b=0 → 0xFFFFFFFF with out_valid in cycle 1. REMU same operands → 0x1234. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1. REM same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- kill in cycle 15 of a DIV → IDLE next edge, out_valid never rises. A subsequent MUL 3*5 returns 15 with correct latency. Async reset asserted mid-CALC → outputs zero immediately, no result emitted.
- XLEN=8 build: MULH 0x80*0x80 → 0x40 in cycle 10. DIV 0x80 / 0xFF → 0x80 in cycle 1.

Source files
------------

// File: rtl/dt1_muldiv_seq.sv
// -----------------------------------------------------------------------------
// dt1_muldiv_seq
// Iterative RV32M multiply/divide unit that sits beside the ALU in execute.
// A radix-2 shift-add multiplier and a restoring divider each retire one
// operand bit per cycle. Operands are reduced to magnitudes on accept and the
// result sign is applied in a single fix-up cycle.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that edge; ready may depend on state only, never on valid.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   operation request
//   in_ready   unit can accept a request (idle)
//   funct3     000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU
//              110 REM 111 REMU
//   a, b       rs1 / rs2 operands
//   kill       synchronous abort; wins over accept and completion
//   out_valid  result available
//   out_ready  consumer takes result
//   result     result value, held while out_valid & ~out_ready
//   busy       unit is not idle
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
// -----------------------------------------------------------------------------
module dt1_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;    // negate product / quotient
  logic              rneg_q, rneg_d;  // remainder takes the dividend's sign

  // ---------------------------------------------------------------------------
  // Accept-time decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, sgn_ovf, special;
  logic [XLEN-1:0] special_res;

  assign accept = in_valid & (state_q == S_IDLE);
  assign is_div = funct3[2];

  // Signed: MUL, MULH, MULHSU (a only), DIV, REM.
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];

  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  // -MIN wraps back to MIN, which read unsigned is exactly the magnitude.
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign b_zero  = (b == '0);
  assign sgn_ovf = ~funct3[0] & (a == MIN_VAL) & (b == ALL_ONES);
  assign special = is_div & (b_zero | sgn_ovf);

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = funct3[1] ? a : ALL_ONES;
    end else begin
      special_res = funct3[1] ? '0 : a;
    end
  end

  // ---------------------------------------------------------------------------
  // One-bit iteration steps
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;

  // Add the multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right; the carry lands in the top bit.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Shift {rem, quot} left and trial-subtract. The remainder stays below the
  // divisor, so one extra bit is enough to see the borrow.
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = rem_sh - {1'b0, opb_q};
  assign div_ok   = ~div_diff[XLEN];
  assign div_next = {(div_ok ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ok};

  // ---------------------------------------------------------------------------
  // Sign fix-up
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quot_fix = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                           : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = funct3;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            acc_d   = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opb_d   = is_div ? b_mag : a_mag;
            cnt_d   = CW'(XLEN);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including accept and completion.
    if (kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dt1_muldiv_seq.sv
// -----------------------------------------------------------------------------
// Bench for dt1_muldiv_seq: a 32-bit and an 8-bit instance share one clock.
// Inputs are driven and outputs sampled on the falling edge. Expected results
// come from an arithmetic RV32M model using wide signed integers.
// -----------------------------------------------------------------------------
module tb_dt1_muldiv_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid = 1'b0, kill = 1'b0, out_ready = 1'b1;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  // 8-bit instance
  logic        in_valid8 = 1'b0, kill8 = 1'b0, out_ready8 = 1'b1;
  logic [2:0]  funct3_8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [7:0]  result8;
  logic [1:0]  state_dbg8;

  dt1_muldiv_seq #(.XLEN(32)) u_dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .state_dbg(state_dbg)
  );

  dt1_muldiv_seq #(.XLEN(8)) u_dut8 (
    .clk(clk), .reset(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .funct3(funct3_8), .a(a8), .b(b8), .kill(kill8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .busy(busy8),
    .state_dbg(state_dbg8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // RV32M semantics at width w, computed with 128-bit signed arithmetic.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] f3,
                                            input logic [31:0] ai,
                                            input logic [31:0] bi);
    logic signed [127:0] ua, ub, sa, sb, p, one, minv;
    logic [31:0] m;
    m    = mask_of(w);
    one  = 128'sd1;
    ua   = {96'd0, ai & m};
    ub   = {96'd0, bi & m};
    sa   = ai[w-1] ? ua - (one <<< w) : ua;
    sb   = bi[w-1] ? ub - (one <<< w) : ub;
    minv = -(one <<< (w - 1));
    p    = '0;
    case (f3)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> w;
      3'd2: p = (sa * ub) >>> w;
      3'd3: p = (ua * ub) >>> w;
      3'd4: p = (ub == 0) ? ua | ~ua : (sa == minv && sb == -1) ? ua : sa / sb;
      3'd5: p = (ub == 0) ? ua | ~ua : ua / ub;
      3'd6: p = (ub == 0) ? ua : (sa == minv && sb == -1) ? 128'sd0 : sa % sb;
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    return p[31:0] & m;
  endfunction

  // Divide-by-zero and signed overflow finish without iterating.
  function automatic bit is_special(input int w, input logic [2:0] f3,
                                    input logic [31:0] ai,
                                    input logic [31:0] bi);
    logic [31:0] m;
    m = mask_of(w);
    if (!f3[2]) return 1'b0;
    if ((bi & m) == 0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && ((ai & m) == ((m >> 1) + 1)) &&
           ((bi & m) == m);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  function automatic logic        ov_of(input bit w8);  return w8 ? out_valid8 : out_valid; endfunction
  function automatic logic        ir_of(input bit w8);  return w8 ? in_ready8 : in_ready; endfunction
  function automatic logic        bz_of(input bit w8);  return w8 ? busy8 : busy; endfunction
  function automatic logic [31:0] res_of(input bit w8); return w8 ? {24'd0, result8} : result; endfunction
  function automatic logic        ordy_of(input bit w8); return w8 ? out_ready8 : out_ready; endfunction

  task automatic set_ordy(input bit w8, input logic v);
    if (w8) out_ready8 = v; else out_ready = v;
  endtask

  // Presents one request; returns at the falling edge of cycle 1.
  task automatic issue(input bit w8, input logic [2:0] f3,
                       input logic [31:0] ai, input logic [31:0] bi);
    chk("in_ready_before_issue", {31'd0, ir_of(w8)}, 32'd1);
    if (w8) begin
      in_valid8 = 1'b1; funct3_8 = f3; a8 = ai[7:0]; b8 = bi[7:0];
    end else begin
      in_valid = 1'b1; funct3 = f3; a = ai; b = bi;
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic do_op(input bit w8, input logic [2:0] f3,
                       input logic [31:0] ai, input logic [31:0] bi,
                       input bit rnd_bp);
    int w, lat, n;
    logic [31:0] m, held;
    bit seen, done, busy_ok;
    w  = w8 ? 8 : 32;
    m  = mask_of(w);
    ai = ai & m;
    bi = bi & m;
    exp_q.push_back(ref_model(w, f3, ai, bi));
    lat = is_special(w, f3, ai, bi) ? 1 : w + 2;
    set_ordy(w8, 1'b1);
    issue(w8, f3, ai, bi);
    n = 1; seen = 0; done = 0; busy_ok = 1; held = '0;
    while (!done && n <= 300) begin
      if (rnd_bp) set_ordy(w8, $urandom_range(0, 3) != 0);
      if (ov_of(w8)) begin
        if (!seen) begin
          seen = 1;
          held = res_of(w8);
          chk($sformatf("latency w%0d f3=%0d", w, f3), n, lat);
          chk($sformatf("result w%0d f3=%0d a=%h b=%h", w, f3, ai, bi),
              held, exp_q.pop_front());
        end else begin
          chk("result_hold", res_of(w8), held);
        end
        if (ordy_of(w8)) done = 1;
      end else if (!bz_of(w8)) begin
        busy_ok = 0;
      end
      @(negedge clk);
      n++;
    end
    set_ordy(w8, 1'b1);
    if (!seen) begin
      chk("timeout_no_out_valid", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else if (!done) begin
      chk("timeout_no_handshake", 32'd0, 32'd1);
    end else begin
      chk("out_valid_drop", {31'd0, ov_of(w8)}, 32'd0);
      chk("in_ready_after", {31'd0, ir_of(w8)}, 32'd1);
    end
    if (lat > 1) chk("busy_while_calc", {31'd0, busy_ok}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] held;
    logic [2:0]  f3;
    logic [31:0] ra, rb, m;
    int          n, mode;
    bit          bad;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst8_state", {30'd0, state_dbg8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed multiply / divide
    do_op(0, 3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    do_op(0, 3'd1, 32'h8000_0000,  32'h8000_0000, 0);
    do_op(0, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    do_op(0, 3'd2, 32'hFFFF_FFFF,  32'd2,         0);
    do_op(0, 3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    do_op(0, 3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    do_op(0, 3'd5, 32'd100,        32'd7,         0);
    do_op(0, 3'd7, 32'd100,        32'd7,         0);
    do_op(0, 3'd0, 32'd0,          32'h1234_5678, 0);

    // Special cases
    do_op(0, 3'd5, 32'h1234,       32'd0,         0);
    do_op(0, 3'd7, 32'h1234,       32'd0,         0);
    do_op(0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op(0, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op(0, 3'd4, 32'hDEAD_BEEF,  32'd0,         0);
    do_op(0, 3'd6, 32'hDEAD_BEEF,  32'd0,         0);

    // Backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue(0, 3'd0, 32'd6, 32'd9);
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_latency", n, 34);
    held = result;
    chk("bp_result", held, 32'd54);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; funct3 = 3'd5; a = $urandom; b = $urandom;
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result_hold", result, held);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ir", {31'd0, in_ready}, 32'd1);

    // Kill in cycle 15 of a DIV
    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (14) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    chk("kill_state", {30'd0, state_dbg}, 32'd0);
    bad = 0;
    repeat (40) begin
      if (out_valid) bad = 1;
      @(negedge clk);
    end
    chk("kill_no_result", {31'd0, bad}, 32'd0);
    do_op(0, 3'd0, 32'd3, 32'd5, 0);

    // Asynchronous reset in the middle of CALC
    issue(0, 3'd1, 32'h7654_3210, 32'h0123_4567);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      if (out_valid) bad = 1;
      @(negedge clk);
    end
    chk("arst_no_result", {31'd0, bad}, 32'd0);

    // 8-bit build
    do_op(1, 3'd1, 32'h80, 32'h80, 0);
    do_op(1, 3'd4, 32'h80, 32'hFF, 0);
    do_op(1, 3'd6, 32'h80, 32'hFF, 0);

    // Randomized traffic on both widths
    for (int i = 0; i < 160; i++) begin
      bit w8;
      w8   = (i % 4 == 3);
      m    = mask_of(w8 ? 8 : 32);
      f3   = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = 32'd0;
      if (mode == 1) begin ra = (m >> 1) + 1; rb = m; end
      if (mode == 2) ra = (m >> 1) + 1;
      if (mode == 3) rb = $urandom_range(1, 15);
      do_op(w8, f3, ra, rb, 1);
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case something stalls outside the bounded loops.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "global timeout");
  end

endmodule
